// File: rtl/newton_update_step_if.sv
// rtl/newton_update_step_if.sv - operand/result bundle between Inverse_Jacob, Newton update step and iteration controller
// Ports (signals):
//   start                 load request from Inverse_Jacob done
//   aj00..aj22            adjugate, ajRC = row R col C, signed
//   d                     reciprocal determinant, signed
//   f0,f1,f2              residual vector, signed
//   x,y,z                 current point, signed
//   busy, valid           status: computing / one-cycle result strobe
//   x_out,y_out,z_out     next point, signed
//   dx,dy,dz              applied correction, signed
interface newton_update_step_if #(parameter int dw = 32);
  logic                 start;
  logic signed [dw-1:0] aj00, aj01, aj02;
  logic signed [dw-1:0] aj10, aj11, aj12;
  logic signed [dw-1:0] aj20, aj21, aj22;
  logic signed [dw-1:0] d;
  logic signed [dw-1:0] f0, f1, f2;
  logic signed [dw-1:0] x, y, z;
  logic                 busy;
  logic                 valid;
  logic signed [dw-1:0] x_out, y_out, z_out;
  logic signed [dw-1:0] dx, dy, dz;

  modport master (
    output start, aj00, aj01, aj02, aj10, aj11, aj12, aj20, aj21, aj22,
    output d, f0, f1, f2, x, y, z,
    input  busy, valid, x_out, y_out, z_out, dx, dy, dz
  );

  modport slave (
    input  start, aj00, aj01, aj02, aj10, aj11, aj12, aj20, aj21, aj22,
    input  d, f0, f1, f2, x, y, z,
    output busy, valid, x_out, y_out, z_out, dx, dy, dz
  );
endinterface

// File: rtl/newton_update_step.sv
// rtl/newton_update_step.sv - Newton-Raphson point update: next = p - d*(Aj*F), one shared multiplier
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   s     slave side of newton_update_step_if (operands in, busy/valid/results out)
// Parameters: dw word width (signed fixed point), FRAC fractional bits.
module newton_update_step #(
  parameter int dw   = 32,
  parameter int FRAC = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  newton_update_step_if.slave  s
);

  localparam int AW = 2*dw + 2;
  localparam logic signed [AW-1:0] VMAX = {{(AW-dw+1){1'b0}}, {(dw-1){1'b1}}};
  localparam logic signed [AW-1:0] VMIN = {{(AW-dw+1){1'b1}}, {(dw-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, SCALE, UPD} state_t;

  state_t state, state_n;

  logic [1:0]           row, col;
  // UPD has produced nx_r; the commit to the outputs happens on the next
  // edge while already in IDLE, so a start seen on that edge is accepted.
  logic                 pend;
  logic                 valid_r;

  logic signed [dw-1:0] aj_r [3][3];
  logic signed [dw-1:0] f_r  [3];
  logic signed [dw-1:0] p_r  [3];
  logic signed [dw-1:0] d_r;
  logic signed [AW-1:0] acc  [3];
  logic signed [dw-1:0] dl_r [3];
  logic signed [dw-1:0] nx_r [3];
  logic signed [dw-1:0] out_r[3];
  logic signed [dw-1:0] dout_r[3];

  logic signed [dw-1:0]   mul_a, mul_b;
  logic signed [2*dw-1:0] prod, prod_sh;
  logic signed [AW-1:0]   prod_ext;
  logic signed [dw-1:0]   s_row, delta_c;
  logic signed [dw:0]     diff [3];
  logic signed [dw-1:0]   nx_c [3];

  function automatic logic signed [dw-1:0] sat_dw(input logic signed [AW-1:0] v);
    if (v > VMAX)      return VMAX[dw-1:0];
    else if (v < VMIN) return VMIN[dw-1:0];
    else               return v[dw-1:0];
  endfunction

  // Single multiplier: Aj*F terms during MAC, s*d during SCALE.
  always_comb begin
    s_row = sat_dw(acc[row] >>> FRAC);
    mul_a = aj_r[row][col];
    mul_b = f_r[col];
    if (state == SCALE) begin
      mul_a = s_row;
      mul_b = d_r;
    end
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{2{prod[2*dw-1]}}, prod};
  assign prod_sh  = prod >>> FRAC;
  assign delta_c  = sat_dw({{2{prod_sh[2*dw-1]}}, prod_sh});

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      diff[i] = {p_r[i][dw-1], p_r[i]} - {dl_r[i][dw-1], dl_r[i]};
      nx_c[i] = sat_dw({{(AW-dw-1){diff[i][dw]}}, diff[i]});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (s.start) state_n = MAC;
      MAC:     if (row == 2'd2 && col == 2'd2) state_n = SCALE;
      SCALE:   if (row == 2'd2) state_n = UPD;
      UPD:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      pend    <= 1'b0;
      valid_r <= 1'b0;
      d_r     <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) aj_r[i][j] <= '0;
        f_r[i]    <= '0;
        p_r[i]    <= '0;
        acc[i]    <= '0;
        dl_r[i]   <= '0;
        nx_r[i]   <= '0;
        out_r[i]  <= '0;
        dout_r[i] <= '0;
      end
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pend) begin
            pend    <= 1'b0;
            valid_r <= 1'b1;
            for (int i = 0; i < 3; i++) begin
              out_r[i]  <= nx_r[i];
              dout_r[i] <= dl_r[i];
            end
          end
          if (s.start) begin
            row <= '0;
            col <= '0;
            aj_r[0][0] <= s.aj00; aj_r[0][1] <= s.aj01; aj_r[0][2] <= s.aj02;
            aj_r[1][0] <= s.aj10; aj_r[1][1] <= s.aj11; aj_r[1][2] <= s.aj12;
            aj_r[2][0] <= s.aj20; aj_r[2][1] <= s.aj21; aj_r[2][2] <= s.aj22;
            d_r    <= s.d;
            f_r[0] <= s.f0; f_r[1] <= s.f1; f_r[2] <= s.f2;
            p_r[0] <= s.x;  p_r[1] <= s.y;  p_r[2] <= s.z;
          end
        end
        MAC: begin
          // First column of each row overwrites, so no separate clear cycle.
          acc[row] <= (col == 2'd0) ? prod_ext : acc[row] + prod_ext;
          if (col == 2'd2) begin
            col <= '0;
            row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
          end else begin
            col <= col + 2'd1;
          end
        end
        SCALE: begin
          dl_r[row] <= delta_c;
          row       <= (row == 2'd2) ? 2'd0 : row + 2'd1;
        end
        UPD: begin
          for (int i = 0; i < 3; i++) nx_r[i] <= nx_c[i];
          pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s.busy  = (state != IDLE) || pend;
  assign s.valid = valid_r;
  assign s.x_out = out_r[0];
  assign s.y_out = out_r[1];
  assign s.z_out = out_r[2];
  assign s.dx    = dout_r[0];
  assign s.dy    = dout_r[1];
  assign s.dz    = dout_r[2];

endmodule
